instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
Parametrised instruction fetch/decode/issue sequencer for the uTPU datapath. It reads a variable-length instruction stream byte-by-byte from the RX FIFO and assembles INSTR_BYTES-wide words plus optional store operands. It decodes each word and issues one command at a time to the execution units (buffer, PE array, quantizer/ReLU) over a valid/ready handshake, then waits for completion. This generation adds parametrised instruction and operand width, a completion timeout, sticky error reporting and an instruction counter.

Parameters:
FIFO_DATA_WIDTH, 8, width of one RX FIFO byte
INSTR_BYTES, 2, bytes per instruction word; IW = INSTR_BYTES*FIFO_DATA_WIDTH
OPCODE_WIDTH, 3, opcode field width, located at instr[OPCODE_WIDTH-1:0]
ADDRESS_SIZE, 9, address field width, located at instr[IW-1 -: ADDRESS_SIZE]
OPERAND_BYTES, 2, extra bytes fetched for STORE with immediate; OW = OPERAND_BYTES*FIFO_DATA_WIDTH
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before a timeout error
COUNT_WIDTH, 16, width of instr_count

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  begin sequencing; sampled only in IDLE
rx_empty  input  1  RX FIFO empty
rx_data  input  FIFO_DATA_WIDTH  RX FIFO head byte (first-word-fall-through)
rx_re  output  1  pop one byte; asserted only when rx_empty=0
cmd_valid  output  1  command presented
cmd_ready  input  1  execution unit accepts the command
cmd_opcode  output  OPCODE_WIDTH  decoded opcode
cmd_flags  output  3  instr[OPCODE_WIDTH+2:OPCODE_WIDTH]
cmd_address  output  ADDRESS_SIZE  address field
cmd_operand  output  OW  store immediate (0 if none)
cmd_done  input  1  single-cycle completion pulse from the execution unit
busy  output  1  high in every state except IDLE, HALT and ERROR
halted  output  1  HALT executed
error  output  1  sticky error
error_code  output  2  0 none, 1 illegal opcode, 2 timeout
instr_count  output  COUNT_WIDTH  instructions retired (including NOP and HALT)

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter, assembly registers and timeout counter cleared. Reset mid-instruction discards any partial bytes already consumed.
- Opcodes: 0 STORE, 1 FETCH, 2 RUN, 3 LOAD, 4 HALT, 5 NOP, 6-7 illegal.
- IDLE: on start=1 go to FETCH.
- FETCH: each cycle with rx_empty=0, pulse rx_re and latch rx_data into byte slot k (little-endian: first byte goes to bits [7:0]). After byte INSTR_BYTES-1, go to DECODE. When rx_empty=1, stall with byte index held and rx_re=0.
- DECODE (1 cycle):
  - STORE with flags[1]=1: go to OPERAND.
  - Illegal opcode: go to ERROR with error_code=1.
  - NOP: increment instr_count, return to FETCH.
  - HALT: increment instr_count, go to HALT.
  - Otherwise: go to ISSUE with cmd_operand=0.
- OPERAND: same byte rules as FETCH. After OPERAND_BYTES bytes, go to ISSUE.
- ISSUE: cmd_valid=1 with all cmd_* fields stable until cmd_valid&&cmd_ready. On acceptance, drop cmd_valid the next cycle and go to WAIT with the timeout counter at 0.
- WAIT:
  - cmd_done=1: increment instr_count, go to FETCH.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT_CYCLES, go to ERROR with error_code=2.
  - cmd_done outside WAIT is ignored.
- HALT: halted=1. ERROR: error=1. Both are terminal until rst; start is ignored in both.
- instr_count wraps modulo 2^COUNT_WIDTH.
- Latency (FIFO never empty, INSTR_BYTES=2): start at cycle 0 → rx_re in cycles 1-2 → DECODE in cycle 3 → cmd_valid in cycle 4. If cmd_ready is already high, the command is accepted in cycle 4.
- rx_re is never asserted in DECODE, ISSUE, WAIT, HALT or ERROR.

Test Plan:
- FIFO holds 0x02,0x00 (RUN, addr 0); cmd_ready=1; cmd_done pulsed 3 cycles after acceptance → exactly one cmd_valid with opcode 2, two rx_re pulses, instr_count=1, back in FETCH.
- STORE immediate: bytes 0x10,0x00,0xCD,0xAB → cmd_flags=3'b010, cmd_operand=0xABCD, four rx_re pulses total.
- FIFO empties after the first byte for 5 cycles, then 0x05 arrives (NOP) → no rx_re during the gap, no cmd_valid, instr_count increments once.
- cmd_ready held low for 10 cycles → cmd_valid and all cmd_* fields stable throughout; one acceptance only.
- Opcode 7 → error=1, error_code=1, busy=0; subsequent bytes are not popped. No cmd_done for 1024 cycles in WAIT → error_code=2.
- HALT (0x04) followed by further bytes → halted=1 and no further rx_re. rst asserted mid-FETCH → all outputs 0, and the next start refetches from the current FIFO head.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/issue sequencer for the uTPU datapath.
// Pulls instruction bytes from a first-word-fall-through RX FIFO, assembles
// little-endian INSTR_BYTES-wide words (plus OPERAND_BYTES of immediate for
// STORE with flags[1]), then issues one command at a time over valid/ready
// and waits for the execution unit's cmd_done pulse.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begin sequencing (only looked at in IDLE)
//   rx_empty, rx_data   FIFO status and head byte
//   rx_re               pop one byte (never while rx_empty)
//   cmd_valid/ready     command handshake
//   cmd_opcode/flags/address/operand  decoded command fields
//   cmd_done            completion pulse, only honoured while waiting
//   busy, halted, error, error_code   status (error is sticky until rst)
//   instr_count         retired instructions, wraps
module instr_sequencer #(
  parameter int unsigned FIFO_DATA_WIDTH = 8,
  parameter int unsigned INSTR_BYTES     = 2,
  parameter int unsigned OPCODE_WIDTH    = 3,
  parameter int unsigned ADDRESS_SIZE    = 9,
  parameter int unsigned OPERAND_BYTES   = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024,
  parameter int unsigned COUNT_WIDTH     = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic                                      rx_empty,
  input  logic [FIFO_DATA_WIDTH-1:0]                rx_data,
  output logic                                      rx_re,
  output logic                                      cmd_valid,
  input  logic                                      cmd_ready,
  output logic [OPCODE_WIDTH-1:0]                   cmd_opcode,
  output logic [2:0]                                cmd_flags,
  output logic [ADDRESS_SIZE-1:0]                   cmd_address,
  output logic [OPERAND_BYTES*FIFO_DATA_WIDTH-1:0]  cmd_operand,
  input  logic                                      cmd_done,
  output logic                                      busy,
  output logic                                      halted,
  output logic                                      error,
  output logic [1:0]                                error_code,
  output logic [COUNT_WIDTH-1:0]                    instr_count
);

  localparam int unsigned IW   = INSTR_BYTES * FIFO_DATA_WIDTH;
  localparam int unsigned MAXB = (INSTR_BYTES > OPERAND_BYTES) ? INSTR_BYTES : OPERAND_BYTES;
  localparam int unsigned BW   = $clog2(MAXB + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_ISSUE, S_WAIT, S_HALT, S_ERROR
  } state_t;

  state_t                  state;
  logic [BW-1:0]           byte_idx;
  logic [IW-1:0]           instr;
  logic [TW-1:0]           tcount;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    unused_instr_bits;

  assign opcode = instr[OPCODE_WIDTH-1:0];
  // Bits between the flags and the address field are reserved and ignored.
  assign unused_instr_bits = ^instr;

  // Gated by rst so a byte is never consumed in the reset cycle; the next
  // start must see the same FIFO head.
  assign rx_re  = !rst && !rx_empty && (state == S_FETCH || state == S_OPERAND);
  assign busy   = (state == S_FETCH) || (state == S_DECODE) || (state == S_OPERAND) ||
                  (state == S_ISSUE) || (state == S_WAIT);
  assign halted = (state == S_HALT);
  assign error  = (state == S_ERROR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_idx    <= '0;
      instr       <= '0;
      tcount      <= '0;
      cmd_valid   <= 1'b0;
      cmd_opcode  <= '0;
      cmd_flags   <= '0;
      cmd_address <= '0;
      cmd_operand <= '0;
      error_code  <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            byte_idx <= '0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (rx_re) begin
            for (int unsigned i = 0; i < INSTR_BYTES; i++)
              if (byte_idx == BW'(i)) instr[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] <= rx_data;
            if (byte_idx == BW'(INSTR_BYTES - 1)) begin
              byte_idx <= '0;
              state    <= S_DECODE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (opcode == OP_STORE && instr[OPCODE_WIDTH+1]) begin
            cmd_opcode  <= opcode;
            cmd_flags   <= instr[OPCODE_WIDTH+2:OPCODE_WIDTH];
            cmd_address <= instr[IW-1 -: ADDRESS_SIZE];
            cmd_operand <= '0;
            state       <= S_OPERAND;
          end else if (opcode > OP_NOP) begin
            error_code <= 2'd1;
            state      <= S_ERROR;
          end else if (opcode == OP_NOP) begin
            instr_count <= instr_count + 1'b1;
            state       <= S_FETCH;
          end else if (opcode == OP_HALT) begin
            instr_count <= instr_count + 1'b1;
            state       <= S_HALT;
          end else begin
            cmd_opcode  <= opcode;
            cmd_flags   <= instr[OPCODE_WIDTH+2:OPCODE_WIDTH];
            cmd_address <= instr[IW-1 -: ADDRESS_SIZE];
            cmd_operand <= '0;
            cmd_valid   <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_OPERAND: begin
          if (rx_re) begin
            for (int unsigned i = 0; i < OPERAND_BYTES; i++)
              if (byte_idx == BW'(i)) cmd_operand[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] <= rx_data;
            if (byte_idx == BW'(OPERAND_BYTES - 1)) begin
              byte_idx  <= '0;
              cmd_valid <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            tcount    <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cmd_done) begin
            instr_count <= instr_count + 1'b1;
            state       <= S_FETCH;
          end else if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
            error_code <= 2'd2;
            state      <= S_ERROR;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        S_HALT:  state <= S_HALT;
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
